jtag_ocimem_ctrl: RTL and testbench
===================================

Name: jtag_ocimem_ctrl

Overview:
- Downstream consumer of the JTAG debug wrapper's sysclk-domain outputs (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
- Owns the on-chip debug memory (OCI RAM). Decodes host JTAG read/write requests and produces MonDReg, monitor_ready and monitor_error, which feed back into the wrapper's capture chain.
- Arbitrates the single-port RAM between the JTAG path and the CPU's Avalon debug slave port.

Parameters:
- ADDR_W, 8, word-address width of OCI RAM (2^ADDR_W x 32-bit words).
- INIT_FILE, "", optional RAM init image; empty means no init.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data from the wrapper, stable while any take_* pulse is high.
- take_action_ocimem_a  in  1  1-cycle pulse: address load / optional read.
- take_no_action_ocimem_a  in  1  1-cycle pulse: streaming read at the current address.
- take_action_ocimem_b  in  1  1-cycle pulse: write jdo[34:3] at the current address.
- avs_address  in  ADDR_W  CPU word address.
- avs_chipselect  in  1  CPU select.
- avs_read  in  1  CPU read strobe.
- avs_write  in  1  CPU write strobe.
- avs_writedata  in  32  CPU write data.
- avs_byteenable  in  4  CPU byte lanes.
- avs_debugaccess  in  1  CPU write permitted only when high.
- avs_readdata  out  32  CPU read data.
- avs_waitrequest  out  1  CPU stall.
- MonDReg  out  32  last JTAG read data.
- monitor_ready  out  1  JTAG op complete.
- monitor_error  out  1  sticky JTAG overrun.

Behaviour:
- Reset (asynchronous, active-low, clk domain only) clears all state:
  - MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, avs_readdata=0, jpend=0.
  - FSM returns to IDLE; avs_waitrequest=1 while reset_n is low.
  - An in-flight access is abandoned. RAM contents are not cleared.
- JTAG capture: any take_* pulse sets jpend and latches jop (LOAD, LOAD_RD, RD, WR) plus jdata=jdo[34:3].
  - take_action_ocimem_a: jdo[35]=1 -> LOAD (MonAReg<=jdo[ADDR_W+16:17]); jdo[34]=1 additionally selects LOAD_RD.
  - take_no_action_ocimem_a -> RD.
  - take_action_ocimem_b -> WR.
  - Priority within a cycle: b > action_a > no_action_a.
  - Capturing any pulse clears monitor_ready in the same cycle.
- Overrun: a pulse arriving while jpend=1 or the FSM is not in IDLE is dropped and sets monitor_error. monitor_error clears only on a LOAD/LOAD_RD.
- FSM states: IDLE, J_RD, C_RD.
- IDLE, jpend=1 (JTAG has priority over a waiting CPU):
  - LOAD: update MonAReg; monitor_ready<=1; stay in IDLE.
  - LOAD_RD / RD: issue RAM read at the new/current address; go to J_RD.
  - WR: write jdata (all byte lanes); MonAReg++; monitor_ready<=1; stay in IDLE.
  - Clear jpend.
- IDLE, jpend=0, CPU read: issue RAM read; go to C_RD; avs_waitrequest=1.
- IDLE, jpend=0, CPU write: avs_waitrequest=0 (zero wait states).
  - Write uses avs_byteenable and only commits if avs_debugaccess=1.
  - Non-debug writes are acked without writing.
- J_RD: MonDReg<=RAM q; MonAReg++; monitor_ready<=1; go to IDLE. Total JTAG read latency is 2 cycles from pulse.
- C_RD: avs_readdata<=RAM q; avs_waitrequest=0 for this cycle; go to IDLE. CPU read has exactly 1 wait state when uncontended.
- avs_waitrequest=1 whenever state!=IDLE or jpend=1, except the C_RD completion cycle.
- MonAReg arithmetic: modulo 2^ADDR_W; the max address wraps to 0.
- Simultaneous JTAG pulse and CPU request: JTAG is served first; the CPU stalls at least 1 cycle. CPU strobes must be held until waitrequest=0.

Optional Feature:
- Macro: OCIMEM_PARITY_EN.
- Defined:
  - RAM widens to 36 bits, with one even-parity bit per byte computed on every write.
  - On a J_RD or C_RD parity mismatch, monitor_error is set (sticky, same clear rule as overrun). Data is still returned unmodified.
- Undefined: 32-bit RAM; no parity logic; monitor_error reflects overrun only.

Decomposition:
- Package jtag_ocimem_pkg:
  - FSM state enum; jop enum.
  - JDO bit positions: JDO_LOAD=35, JDO_RD=34, JDO_DATA_HI=34, JDO_DATA_LO=3, JDO_ADDR_LO=17.
  - Parity width constant.
- Sub-module jtag_ocimem_ram: single-port synchronous RAM, 1-cycle read, byte-enabled write, width selected by OCIMEM_PARITY_EN.

Test Plan:
- Reset mid J_RD -> all outputs return to reset values immediately; after release, RD reads address 0.
- take_action_ocimem_a, jdo[35]=1, jdo[34]=0, addr=0x10; then take_action_ocimem_b x2 with data 0xDEADBEEF and 0x12345678 -> RAM[0x10]=0xDEADBEEF, RAM[0x11]=0x12345678; MonAReg=0x12; monitor_ready=1 after each.
- LOAD_RD addr=0x10, then RD -> MonDReg=0xDEADBEEF 2 cycles after the first pulse; MonDReg=0x12345678 after the second; MonAReg=0x12.
- LOAD addr=0xFF, WR 0xA5A5A5A5, RD -> write lands at 0xFF; read returns RAM[0x00] (wrap).
- CPU read of 0x10 asserted in the same cycle as a JTAG WR to 0x20 -> JTAG served first; waitrequest high 2 cycles; readdata=0xDEADBEEF. CPU write with debugaccess=0 -> acked with RAM unchanged.
- Second take_no_action_ocimem_a one cycle after the first -> monitor_error=1 and dropped pulse has no effect; subsequent LOAD clears it. With OCIMEM_PARITY_EN, a forced parity-bit flip on a read -> monitor_error=1.

Source files
------------

// File: rtl/jtag_ocimem_pkg.sv
// Shared types and constants for the JTAG OCI memory controller.
// Optional feature macro: OCIMEM_PARITY_EN (adds per-byte even parity to the RAM).
package jtag_ocimem_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_J_RD = 2'd1,
    ST_C_RD = 2'd2
  } state_t;

  // Latched JTAG operation
  typedef enum logic [1:0] {
    JOP_LOAD    = 2'd0,
    JOP_LOAD_RD = 2'd1,
    JOP_RD      = 2'd2,
    JOP_WR      = 2'd3
  } jop_t;

  // Bit positions inside the 38-bit jdo word
  localparam int JDO_LOAD    = 35;
  localparam int JDO_RD      = 34;
  localparam int JDO_DATA_HI = 34;
  localparam int JDO_DATA_LO = 3;
  localparam int JDO_ADDR_LO = 17;

  // One parity bit per data byte
  localparam int PAR_W = 4;

`ifdef OCIMEM_PARITY_EN
  localparam int RAM_W = 32 + PAR_W;
`else
  localparam int RAM_W = 32;
`endif

  // Even parity per byte: the stored bit makes each byte+bit have an even number of ones
  function automatic logic [PAR_W-1:0] byte_parity(input logic [31:0] d);
    logic [PAR_W-1:0] p;
    for (int i = 0; i < PAR_W; i++) p[i] = ^d[8*i +: 8];
    return p;
  endfunction

endpackage

// File: rtl/jtag_ocimem_ram.sv
// Single-port synchronous OCI RAM: 1-cycle registered read, byte-enabled write.
// Width is 32 bits, or 36 bits (4 parity bits) when OCIMEM_PARITY_EN is defined.
// Each byte lane's parity bit is written together with its data byte.
module jtag_ocimem_ram
  import jtag_ocimem_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [RAM_W-1:0]  wdata,
  output logic [RAM_W-1:0]  q
);

  // Init images are loaded by the implementation flow (memory init attribute),
  // so the name is kept as a parameter and not consumed here.
  localparam bit unused_init_file = (INIT_FILE != "");

  logic [RAM_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Byte-enabled write and read-before-write registered output
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
`ifdef OCIMEM_PARITY_EN
          mem[addr][32+i] <= wdata[32+i];
`endif
        end
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/jtag_ocimem_ctrl.sv
// OCI memory controller: decodes JTAG wrapper requests, owns the OCI RAM and
// shares it with the CPU Avalon debug slave. JTAG always wins the RAM port.
// Optional feature macro: OCIMEM_PARITY_EN (read parity errors set monitor_error).
//
// Avalon handshake: the CPU holds chipselect/read/write and address/data
// stable until it samples avs_waitrequest=0 at a rising edge; that edge ends
// the transfer, and avs_readdata is valid in that same cycle.
module jtag_ocimem_ctrl
  import jtag_ocimem_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  state_t            state;
  jop_t              jop;
  jop_t              cap_jop;
  logic              jpend;
  logic [31:0]       jdata;
  logic [ADDR_W-1:0] jaddr;
  logic [ADDR_W-1:0] mon_areg;
  logic [31:0]       readdata_q;

  logic              any_pulse;
  logic              accept;
  logic              cpu_rd;
  logic              cpu_wr;
  logic              cpu_go;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata32;
  logic [RAM_W-1:0]  ram_wdata;
  logic [RAM_W-1:0]  ram_q;
  logic              par_bad;

  // jdo bits outside the opcode/data fields carry nothing for this block
  logic unused_jdo;
  assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

  assign any_pulse = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign accept    = any_pulse && !jpend && (state == ST_IDLE);
  assign cpu_rd    = avs_chipselect && avs_read;
  assign cpu_wr    = avs_chipselect && avs_write && !avs_read;
  // The CPU only gets the port when no JTAG work is pending or arriving
  assign cpu_go    = (state == ST_IDLE) && !jpend && !any_pulse;

  // Decode the captured pulse; b beats action_a beats no_action_a.
  // action_a without the load bit is treated as a plain read at MonAReg.
  always_comb begin
    cap_jop = JOP_RD;
    if (take_action_ocimem_b) begin
      cap_jop = JOP_WR;
    end else if (take_action_ocimem_a && jdo[JDO_LOAD]) begin
      cap_jop = jdo[JDO_RD] ? JOP_LOAD_RD : JOP_LOAD;
    end
  end

  // RAM port steering: pending JTAG op first, then a CPU access
  always_comb begin
    ram_we      = 1'b0;
    ram_addr    = mon_areg;
    ram_be      = 4'hF;
    ram_wdata32 = jdata;
    if (state == ST_IDLE) begin
      if (jpend) begin
        if (jop == JOP_LOAD_RD) ram_addr = jaddr;
        if (jop == JOP_WR)      ram_we   = 1'b1;
      end else if (cpu_go && (cpu_rd || cpu_wr)) begin
        ram_addr    = avs_address;
        ram_be      = avs_byteenable;
        ram_wdata32 = avs_writedata;
        ram_we      = cpu_wr && avs_debugaccess;
      end
    end
  end

`ifdef OCIMEM_PARITY_EN
  assign ram_wdata = {byte_parity(ram_wdata32), ram_wdata32};
  assign par_bad   = (ram_q[RAM_W-1:32] != byte_parity(ram_q[31:0]));
`else
  assign ram_wdata = ram_wdata32;
  assign par_bad   = 1'b0;
`endif

  jtag_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  // Stall the CPU whenever the port is busy or claimed by JTAG; release it
  // in the C_RD cycle and for zero-wait-state writes in an idle cycle.
  always_comb begin
    avs_waitrequest = 1'b0;
    if (!reset_n) begin
      avs_waitrequest = 1'b1;
    end else if (state == ST_C_RD) begin
      avs_waitrequest = 1'b0;
    end else if ((state != ST_IDLE) || jpend || any_pulse) begin
      avs_waitrequest = 1'b1;
    end else if (cpu_rd) begin
      avs_waitrequest = 1'b1;
    end
  end

  // Read data is presented straight from the RAM in the completion cycle and held afterwards
  assign avs_readdata = (state == ST_C_RD) ? ram_q[31:0] : readdata_q;

  // Controller FSM: JTAG capture, op execution, CPU reads, status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      jop           <= JOP_LOAD;
      jpend         <= 1'b0;
      jdata         <= '0;
      jaddr         <= '0;
      mon_areg      <= '0;
      MonDReg       <= '0;
      readdata_q    <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (jpend) begin
            jpend <= 1'b0;
            case (jop)
              JOP_LOAD: begin
                mon_areg      <= jaddr;
                monitor_ready <= 1'b1;
                monitor_error <= 1'b0;
              end
              JOP_LOAD_RD: begin
                mon_areg      <= jaddr;
                monitor_error <= 1'b0;
                state         <= ST_J_RD;
              end
              JOP_RD: begin
                state <= ST_J_RD;
              end
              default: begin
                mon_areg      <= mon_areg + 1'b1;
                monitor_ready <= 1'b1;
              end
            endcase
          end else if (cpu_go && cpu_rd) begin
            state <= ST_C_RD;
          end
        end
        ST_J_RD: begin
          MonDReg       <= ram_q[31:0];
          mon_areg      <= mon_areg + 1'b1;
          monitor_ready <= 1'b1;
          if (par_bad) monitor_error <= 1'b1;
          state         <= ST_IDLE;
        end
        ST_C_RD: begin
          readdata_q <= ram_q[31:0];
          if (par_bad) monitor_error <= 1'b1;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Capture sits after execution so a dropped pulse's error wins over a same-cycle LOAD clear
      if (any_pulse) begin
        if (accept) begin
          jpend         <= 1'b1;
          jop           <= cap_jop;
          jdata         <= jdo[JDO_DATA_HI:JDO_DATA_LO];
          jaddr         <= jdo[JDO_ADDR_LO+ADDR_W-1:JDO_ADDR_LO];
          monitor_ready <= 1'b0;
        end else begin
          monitor_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_ocimem_ctrl.sv
// Self-checking bench for jtag_ocimem_ctrl (ADDR_W=8).
// Optional feature macro: OCIMEM_PARITY_EN enables the parity-flip scenario.
module tb_jtag_ocimem_ctrl;

  localparam int OP_LOAD    = 0;
  localparam int OP_LOAD_RD = 1;
  localparam int OP_RD      = 2;
  localparam int OP_WR      = 3;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_no_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic [7:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_debugaccess;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  // Reference model and scoreboard
  logic [31:0] m_mem [0:255];
  logic [7:0]  m_addr;
  logic        m_err;
  logic [31:0] exp_q[$];
  logic [31:0] cpu_q[$];

  int checks = 0;
  int errors = 0;

  jtag_ocimem_ctrl #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_chipselect          (avs_chipselect),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Wait (sampling on falling edges) for monitor_ready; lat counts cycles after the capture edge
  task automatic wait_ready(output int lat);
    for (lat = 0; lat < 10; lat++) begin
      @(negedge clk);
      if (monitor_ready) break;
    end
  endtask

  // Drive one JTAG operation, update the model, and check completion
  task automatic jtag_op(input int op, input logic [31:0] val, input string tag);
    logic [37:0] v;
    int          lat;
    logic [31:0] exp;
    v = '0;
    case (op)
      OP_LOAD: begin
        v[35] = 1'b1; v[24:17] = val[7:0];
        m_addr = val[7:0]; m_err = 1'b0;
      end
      OP_LOAD_RD: begin
        v[35] = 1'b1; v[34] = 1'b1; v[24:17] = val[7:0];
        exp_q.push_back(m_mem[val[7:0]]);
        m_addr = val[7:0] + 8'd1; m_err = 1'b0;
      end
      OP_RD: begin
        exp_q.push_back(m_mem[m_addr]);
        m_addr = m_addr + 8'd1;
      end
      default: begin
        v[34:3] = val;
        m_mem[m_addr] = val;
        m_addr = m_addr + 8'd1;
      end
    endcase
    @(posedge clk); #1;
    jdo = v;
    if (op == OP_WR) take_action_ocimem_b = 1'b1;
    else if (op == OP_RD) take_no_action_ocimem_a = 1'b1;
    else take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    wait_ready(lat);
    check_eq({tag, "_ready"}, monitor_ready, 1);
    if (op == OP_LOAD_RD || op == OP_RD) begin
      check_eq({tag, "_lat"}, lat, 2);
      exp = exp_q.pop_front();
      check_eq({tag, "_mondreg"}, MonDReg, exp);
    end else begin
      check_eq({tag, "_lat"}, lat, 1);
    end
  endtask

  // CPU read: expected data queued at issue, compared at the acknowledge cycle
  task automatic cpu_read(input logic [7:0] a, input int exp_waits, input string tag);
    int          waits;
    logic [31:0] exp;
    cpu_q.push_back(m_mem[a]);
    @(posedge clk); #1;
    avs_address = a; avs_chipselect = 1'b1; avs_read = 1'b1;
    for (waits = 0; waits < 10; waits++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
    end
    check_eq({tag, "_waits"}, waits, exp_waits);
    exp = cpu_q.pop_front();
    check_eq({tag, "_data"}, avs_readdata, exp);
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_read = 1'b0;
  endtask

  // CPU write: zero wait states expected when uncontended
  task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic dbg, input string tag);
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_debugaccess = dbg;
    avs_chipselect = 1'b1; avs_write = 1'b1;
    @(negedge clk);
    check_eq({tag, "_ack"}, avs_waitrequest, 0);
    if (dbg) begin
      for (int i = 0; i < 4; i++) if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
    end
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_write = 1'b0; avs_debugaccess = 1'b0;
  endtask

  initial begin
    int stall;
    logic [37:0] v;
    logic [31:0] exp;
    reset_n = 1'b0;
    jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    avs_address = '0; avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = 4'hF; avs_debugaccess = 1'b0;
    m_addr = '0; m_err = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_waitreq", avs_waitrequest, 1);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_mondreg", MonDReg, 0);
    check_eq("rst_ready", monitor_ready, 0);
    check_eq("rst_error", monitor_error, 0);
    check_eq("rst_readdata", avs_readdata, 0);
    check_eq("idle_waitreq", avs_waitrequest, 0);

    // Seed address 0 from the CPU side
    cpu_write(8'h00, 32'h0BADF00D, 4'hF, 1'b1, "cw0");

    // LOAD then two writes, readback via LOAD_RD/RD; a further write proves MonAReg=0x12
    jtag_op(OP_LOAD, 32'h10, "load10");
    jtag_op(OP_WR, 32'hDEADBEEF, "wr1");
    jtag_op(OP_WR, 32'h12345678, "wr2");
    jtag_op(OP_LOAD_RD, 32'h10, "ldrd10");
    jtag_op(OP_RD, 32'h0, "rd11");
    jtag_op(OP_WR, 32'h00C0FFEE, "wr12");
    cpu_read(8'h12, 1, "cr12");
    cpu_read(8'h11, 1, "cr11");

    // Address wrap at 0xFF
    jtag_op(OP_LOAD, 32'hFF, "loadff");
    jtag_op(OP_WR, 32'hA5A5A5A5, "wrff");
    jtag_op(OP_RD, 32'h0, "rdwrap");
    jtag_op(OP_LOAD_RD, 32'hFF, "ldrdff");

    // CPU writes: non-debug write ignored, byte lanes honoured
    cpu_write(8'h10, 32'hFFFFFFFF, 4'hF, 1'b0, "cwnodbg");
    cpu_read(8'h10, 1, "cr10");
    cpu_write(8'h30, 32'h11223344, 4'hF, 1'b1, "cw30");
    cpu_write(8'h30, 32'hAABBCCDD, 4'b0101, 1'b1, "cw30be");
    cpu_read(8'h30, 1, "cr30");

    // Contention: JTAG write to 0x20 and CPU read of 0x10 in the same cycle
    jtag_op(OP_LOAD, 32'h20, "load20");
    m_mem[8'h20] = 32'h600DCAFE;
    m_addr = 8'h21;
    cpu_q.push_back(m_mem[8'h10]);
    v = '0; v[34:3] = 32'h600DCAFE;
    @(posedge clk); #1;
    jdo = v; take_action_ocimem_b = 1'b1;
    avs_address = 8'h10; avs_chipselect = 1'b1; avs_read = 1'b1;
    @(negedge clk);
    stall = avs_waitrequest ? 1 : 0;
    @(posedge clk); #1;
    take_action_ocimem_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!avs_waitrequest) break;
      stall++;
    end
    check_eq("contend_stall_ge2", (stall >= 2) ? 1 : 0, 1);
    check_eq("contend_stall_le3", (stall <= 3) ? 1 : 0, 1);
    exp = cpu_q.pop_front();
    check_eq("contend_data", avs_readdata, exp);
    @(posedge clk); #1;
    avs_chipselect = 1'b0; avs_read = 1'b0;
    check_eq("contend_jready", monitor_ready, 1);
    jtag_op(OP_LOAD_RD, 32'h20, "ldrd20");

    // Overrun: second RD one cycle after the first is dropped
    jtag_op(OP_LOAD, 32'h10, "load10b");
    exp_q.push_back(m_mem[m_addr]);
    m_addr = m_addr + 8'd1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    take_no_action_ocimem_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (monitor_ready) break;
    end
    exp = exp_q.pop_front();
    check_eq("ovr_mondreg", MonDReg, exp);
    check_eq("ovr_error", monitor_error, 1);
    jtag_op(OP_RD, 32'h0, "ovr_next");
    check_eq("ovr_error_sticky", monitor_error, 1);
    jtag_op(OP_LOAD, 32'h00, "load_clr");
    check_eq("ovr_error_clr", monitor_error, 0);

`ifdef OCIMEM_PARITY_EN
    // Parity: corrupt a stored parity bit, read returns data but flags an error
    dut.u_ram.mem[8'h10][32] = ~dut.u_ram.mem[8'h10][32];
    jtag_op(OP_LOAD_RD, 32'h10, "par_rd");
    check_eq("par_error", monitor_error, 1);
    jtag_op(OP_LOAD, 32'h00, "par_clr");
    check_eq("par_error_clr", monitor_error, 0);
`endif

    // Reset in the middle of a JTAG read
    v = '0; v[35] = 1'b1; v[34] = 1'b1; v[24:17] = 8'h12;
    @(posedge clk); #1;
    jdo = v; take_action_ocimem_a = 1'b1;
    @(posedge clk); #1;
    take_action_ocimem_a = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_mondreg", MonDReg, 0);
    check_eq("mid_rst_ready", monitor_ready, 0);
    check_eq("mid_rst_error", monitor_error, 0);
    check_eq("mid_rst_readdata", avs_readdata, 0);
    check_eq("mid_rst_waitreq", avs_waitrequest, 1);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    m_addr = 8'h00; m_err = 1'b0;
    jtag_op(OP_RD, 32'h0, "post_rst_rd0");
    check_eq("post_rst_error", monitor_error, m_err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
